// File: rtl/fofb_setpoint_pkg.sv
// Shared definitions for the FOFB setpoint streamer: FSM encoding, counter width,
// writeData field positions and the saturating overrun increment.
package fofb_setpoint_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2,
        ST_SEND = 2'd3
    } state_t;

    localparam int OVERRUN_W = 16;
    localparam int GAIN_LSB  = 0;
    localparam int CLIP_LSB  = 0;

    function automatic logic [OVERRUN_W-1:0] sat_inc(input logic [OVERRUN_W-1:0] value);
        logic [OVERRUN_W-1:0] result;
        if (value == {OVERRUN_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + OVERRUN_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/fofb_setpoint_scale.sv
// One-channel datapath: Q1.(GAIN_WIDTH-1) gain, soft-start ramp, symmetric clip.
module fofb_setpoint_scale #(
    parameter int DIN_WIDTH        = 26,
    parameter int GAIN_WIDTH       = 16,
    parameter int DOUT_WIDTH       = 32,
    parameter int SOFT_START_STEPS = 1024,
    localparam int RAMP_W          = $clog2(SOFT_START_STEPS) + 1
) (
    input  logic signed [DIN_WIDTH-1:0]  din,
    input  logic signed [GAIN_WIDTH-1:0] gain,
    input  logic        [RAMP_W-1:0]     ramp,
    input  logic        [DOUT_WIDTH-2:0] clip,
    output logic signed [DOUT_WIDTH-1:0] dout
);
    localparam int PROD_W = DIN_WIDTH + GAIN_WIDTH;
    localparam int RMUL_W = PROD_W + RAMP_W + 1;
    localparam int EXT_W  = RMUL_W + DOUT_WIDTH;
    localparam int SHIFT  = $clog2(SOFT_START_STEPS);

    logic signed [PROD_W-1:0] prod_s;
    logic signed [PROD_W-1:0] gained_s;
    logic signed [RMUL_W-1:0] ramped_s;
    logic signed [EXT_W-1:0]  value_s;
    logic signed [EXT_W-1:0]  limit_s;

    // Gain, ramp (exact bypass at full scale) and clip, all in wide signed arithmetic
    always_comb begin
        prod_s   = PROD_W'(din) * PROD_W'(gain);
        gained_s = prod_s >>> (GAIN_WIDTH - 1);
        ramped_s = RMUL_W'(gained_s) * RMUL_W'($signed({1'b0, ramp}));
        if (ramp == RAMP_W'(SOFT_START_STEPS)) begin
            value_s = EXT_W'(gained_s);
        end else begin
            value_s = EXT_W'(ramped_s >>> SHIFT);
        end
        limit_s = $signed({{(EXT_W - DOUT_WIDTH + 1){1'b0}}, clip});
        if (value_s > limit_s) begin
            dout = DOUT_WIDTH'(limit_s);
        end else if (value_s < -limit_s) begin
            dout = DOUT_WIDTH'(-limit_s);
        end else begin
            dout = DOUT_WIDTH'(value_s);
        end
    end

endmodule

// File: rtl/fofb_setpoint_stream.sv
// FOFB setpoint streamer: toggle-handshake frame in, per-channel gain/ramp/clip, AXI4-Stream out.
// Define FOFB_SETPOINT_SHADOW_EN to double-buffer gain/clip tables, swapped at each frame load.
module fofb_setpoint_stream
    import fofb_setpoint_pkg::*;
#(
    parameter int CHANNEL_COUNT    = 32,
    parameter int DIN_WIDTH        = 26,
    parameter int GAIN_WIDTH       = 16,
    parameter int DOUT_WIDTH       = 32,
    parameter int SOFT_START_STEPS = 1024,
    localparam int ADDR_W          = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1,
    localparam int RAMP_W          = $clog2(SOFT_START_STEPS) + 1
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               fofbEnabled,
    input  logic                               gainWriteStrobe,
    input  logic                               clipWriteStrobe,
    input  logic [ADDR_W-1:0]                  writeAddress,
    input  logic [31:0]                        writeData,
    input  logic                               dinToggle,
    input  logic [CHANNEL_COUNT*DIN_WIDTH-1:0] din,
    output logic                               SETPOINT_TVALID,
    input  logic                               SETPOINT_TREADY,
    output logic                               SETPOINT_TLAST,
    output logic [DOUT_WIDTH-1:0]              SETPOINT_TDATA,
    output logic                               busy,
    output logic [OVERRUN_W-1:0]               overrunCount
);
    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(CHANNEL_COUNT - 1);

    state_t                       state_r, state_next_s;
    logic                         hist_r;
    logic signed [DIN_WIDTH-1:0]  frame_r [CHANNEL_COUNT];
    logic signed [GAIN_WIDTH-1:0] gain_r  [CHANNEL_COUNT];
    logic        [DOUT_WIDTH-2:0] clip_r  [CHANNEL_COUNT];
    logic [ADDR_W-1:0]            k_r;
    logic [RAMP_W-1:0]            ramp_r;
    logic [OVERRUN_W-1:0]         overrun_r;
    logic signed [DOUT_WIDTH-1:0] tdata_r, scaled_s;
    logic                         tvalid_r, tlast_r, busy_r;
    logic                         load_s, calc_s, handshake_s, overrun_s, edge_s, addr_ok_s;
    logic                         unused_s;

    assign edge_s    = (dinToggle != hist_r);
    assign addr_ok_s = ({1'b0, writeAddress} < (ADDR_W + 1)'(CHANNEL_COUNT));
    assign unused_s  = ^writeData;

    assign SETPOINT_TVALID = tvalid_r;
    assign SETPOINT_TLAST  = tlast_r;
    assign SETPOINT_TDATA  = tdata_r;
    assign busy            = busy_r;
    assign overrunCount    = overrun_r;

    fofb_setpoint_scale #(
        .DIN_WIDTH        (DIN_WIDTH),
        .GAIN_WIDTH       (GAIN_WIDTH),
        .DOUT_WIDTH       (DOUT_WIDTH),
        .SOFT_START_STEPS (SOFT_START_STEPS)
    ) u_scale (
        .din  (frame_r[k_r]),
        .gain (gain_r[k_r]),
        .ramp (ramp_r),
        .clip (clip_r[k_r]),
        .dout (scaled_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (edge_s) state_next_s = ST_LOAD;
                else        state_next_s = ST_IDLE;
            end
            ST_LOAD: state_next_s = ST_CALC;
            ST_CALC: state_next_s = ST_SEND;
            ST_SEND: begin
                if (!SETPOINT_TREADY)  state_next_s = ST_SEND;
                else if (k_r == LAST_K) state_next_s = ST_IDLE;
                else                    state_next_s = ST_CALC;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Per-state control strobes; a toggle seen outside IDLE is a dropped frame
    always_comb begin
        load_s      = 1'b0;
        calc_s      = 1'b0;
        handshake_s = 1'b0;
        case (state_r)
            ST_LOAD: load_s      = 1'b1;
            ST_CALC: calc_s      = 1'b1;
            ST_SEND: handshake_s = SETPOINT_TREADY;
            default: load_s      = 1'b0;
        endcase
        if (state_r != ST_IDLE) overrun_s = edge_s;
        else                    overrun_s = 1'b0;
    end

    // Frame register, ramp, channel index, stream outputs and overrun counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hist_r    <= dinToggle;
            busy_r    <= 1'b0;
            tvalid_r  <= 1'b0;
            tlast_r   <= 1'b0;
            tdata_r   <= {DOUT_WIDTH{1'b0}};
            k_r       <= {ADDR_W{1'b0}};
            ramp_r    <= {RAMP_W{1'b0}};
            overrun_r <= {OVERRUN_W{1'b0}};
            for (int i = 0; i < CHANNEL_COUNT; i++) frame_r[i] <= {DIN_WIDTH{1'b0}};
        end else begin
            hist_r <= dinToggle;
            busy_r <= (state_next_s != ST_IDLE);
            if (overrun_s) overrun_r <= sat_inc(overrun_r);
            if (load_s) begin
                for (int i = 0; i < CHANNEL_COUNT; i++) frame_r[i] <= din[i*DIN_WIDTH +: DIN_WIDTH];
                k_r <= {ADDR_W{1'b0}};
                if (!fofbEnabled)                                ramp_r <= {RAMP_W{1'b0}};
                else if (ramp_r != RAMP_W'(SOFT_START_STEPS))    ramp_r <= ramp_r + RAMP_W'(1);
            end
            if (calc_s) begin
                tdata_r  <= scaled_s;
                tvalid_r <= 1'b1;
                tlast_r  <= (k_r == LAST_K);
            end
            if (handshake_s) begin
                tvalid_r <= 1'b0;
                tlast_r  <= 1'b0;
                if (k_r != LAST_K) k_r <= k_r + ADDR_W'(1);
            end
        end
    end

`ifdef FOFB_SETPOINT_SHADOW_EN
    logic signed [GAIN_WIDTH-1:0] gain_sh_r [CHANNEL_COUNT];
    logic        [DOUT_WIDTH-2:0] clip_sh_r [CHANNEL_COUNT];

    // Writes land in shadow; the whole shadow set becomes active at frame load
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
                gain_sh_r[i] <= {GAIN_WIDTH{1'b0}};
                clip_sh_r[i] <= {(DOUT_WIDTH-1){1'b0}};
                gain_r[i]    <= {GAIN_WIDTH{1'b0}};
                clip_r[i]    <= {(DOUT_WIDTH-1){1'b0}};
            end
        end else begin
            if (gainWriteStrobe && addr_ok_s) gain_sh_r[writeAddress] <= writeData[GAIN_LSB +: GAIN_WIDTH];
            if (clipWriteStrobe && addr_ok_s) clip_sh_r[writeAddress] <= writeData[CLIP_LSB +: DOUT_WIDTH-1];
            if (load_s) begin
                gain_r <= gain_sh_r;
                clip_r <= clip_sh_r;
            end
        end
    end
`else
    // Writes go straight to the active tables and hit any channel computed afterwards
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
                gain_r[i] <= {GAIN_WIDTH{1'b0}};
                clip_r[i] <= {(DOUT_WIDTH-1){1'b0}};
            end
        end else begin
            if (gainWriteStrobe && addr_ok_s) gain_r[writeAddress] <= writeData[GAIN_LSB +: GAIN_WIDTH];
            if (clipWriteStrobe && addr_ok_s) clip_r[writeAddress] <= writeData[CLIP_LSB +: DOUT_WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_fofb_setpoint_stream.sv
// Self-checking bench for fofb_setpoint_stream (4 channels, 4-step soft start) against a frame-level model.
module tb_fofb_setpoint_stream;
    localparam int CH    = 4;
    localparam int DINW  = 26;
    localparam int STEPS = 4;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 fofbEnabled = 1'b1;
    logic                 gainWriteStrobe = 1'b0;
    logic                 clipWriteStrobe = 1'b0;
    logic [1:0]           writeAddress = 2'd0;
    logic [31:0]          writeData = 32'd0;
    logic                 dinToggle = 1'b0;
    logic [CH*DINW-1:0]   din = '0;
    logic                 SETPOINT_TVALID, SETPOINT_TLAST, SETPOINT_TREADY, busy;
    logic [31:0]          SETPOINT_TDATA;
    logic [15:0]          overrunCount;

    fofb_setpoint_stream #(
        .CHANNEL_COUNT(CH), .DIN_WIDTH(DINW), .GAIN_WIDTH(16), .DOUT_WIDTH(32), .SOFT_START_STEPS(STEPS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .fofbEnabled(fofbEnabled),
        .gainWriteStrobe(gainWriteStrobe), .clipWriteStrobe(clipWriteStrobe),
        .writeAddress(writeAddress), .writeData(writeData),
        .dinToggle(dinToggle), .din(din),
        .SETPOINT_TVALID(SETPOINT_TVALID), .SETPOINT_TREADY(SETPOINT_TREADY),
        .SETPOINT_TLAST(SETPOINT_TLAST), .SETPOINT_TDATA(SETPOINT_TDATA),
        .busy(busy), .overrunCount(overrunCount)
    );

    always #5 clk = ~clk;

    typedef struct { int data; bit last; } exp_t;
    exp_t exp_q[$];
    int   got_q[$];
    int   checks = 0;
    int   fails = 0;
    int   ready_mode = 0;          // 0 always ready, 1 random, 2 held low
    int   m_gain[CH], m_clip[CH], m_gain_w[CH], m_clip_w[CH];
    int   ramp_m = 0;
    int   frame_din[CH];

    function automatic longint floordiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Setpoint from first principles: value = din*gain/2^15, scaled by ramp/STEPS, clipped
    function automatic int model_word(input int d, input int g, input int r, input int c);
        longint p;
        p = floordiv(longint'(d) * longint'(g), 64'sd32768);
        if (r != STEPS) p = floordiv(p * r, STEPS);
        if (p > c) p = c;
        else if (p < -longint'(c)) p = -longint'(c);
        return int'(p);
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic write_tbl(input int idx, input int g, input int c);
        @(posedge clk); #1;
        writeAddress = 2'(idx); writeData = 32'(g); gainWriteStrobe = 1'b1;
        @(posedge clk); #1;
        gainWriteStrobe = 1'b0; writeData = 32'(c); clipWriteStrobe = 1'b1;
        @(posedge clk); #1;
        clipWriteStrobe = 1'b0;
        m_gain_w[idx] = g; m_clip_w[idx] = c;
`ifndef FOFB_SETPOINT_SHADOW_EN
        m_gain[idx] = g; m_clip[idx] = c;
`endif
    endtask

    // One write cycle with both strobes: gain takes data[15:0], clip takes data[30:0]
    task automatic write_both(input int idx, input logic [31:0] data);
        logic signed [15:0] g16;
        g16 = data[15:0];
        @(posedge clk); #1;
        writeAddress = 2'(idx); writeData = data; gainWriteStrobe = 1'b1; clipWriteStrobe = 1'b1;
        @(posedge clk); #1;
        gainWriteStrobe = 1'b0; clipWriteStrobe = 1'b0;
        m_gain_w[idx] = int'(g16); m_clip_w[idx] = int'({1'b0, data[30:0]});
`ifndef FOFB_SETPOINT_SHADOW_EN
        m_gain[idx] = m_gain_w[idx]; m_clip[idx] = m_clip_w[idx];
`endif
    endtask

    task automatic start_frame();
        if (!fofbEnabled)      ramp_m = 0;
        else if (ramp_m < STEPS) ramp_m = ramp_m + 1;
`ifdef FOFB_SETPOINT_SHADOW_EN
        m_gain = m_gain_w; m_clip = m_clip_w;
`endif
        for (int k = 0; k < CH; k++)
            exp_q.push_back('{data: model_word(frame_din[k], m_gain[k], ramp_m, m_clip[k]), last: (k == CH-1)});
        @(posedge clk); #1;
        for (int k = 0; k < CH; k++) din[k*DINW +: DINW] = DINW'(frame_din[k]);
        dinToggle = ~dinToggle;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin @(posedge clk); n++; end
        if (exp_q.size() != 0) begin
            checks++; fails++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    function automatic int rand_din();
        return int'($urandom_range(0, 32'h03FF_FFFF)) - 33554432;
    endfunction

    // Ready driver
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       SETPOINT_TREADY = 1'b1;
            1:       SETPOINT_TREADY = 1'($urandom_range(0, 1));
            default: SETPOINT_TREADY = 1'b0;
        endcase
    end

    // Compare process: every handshake against the model, plus hold-stability under backpressure
    bit prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
    logic [31:0] prev_d = 32'd0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                checks++;
                if (!SETPOINT_TVALID || SETPOINT_TDATA !== prev_d || SETPOINT_TLAST !== prev_l) begin
                    fails++;
                    $display("FAIL hold_stable got v=%0b d=%0d l=%0b exp v=1 d=%0d l=%0b",
                             SETPOINT_TVALID, $signed(SETPOINT_TDATA), SETPOINT_TLAST, $signed(prev_d), prev_l);
                end
            end
            if (SETPOINT_TVALID && SETPOINT_TREADY) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_word got=%0d exp=none", $signed(SETPOINT_TDATA));
                end else begin
                    e = exp_q.pop_front();
                    if ($signed(SETPOINT_TDATA) != e.data || SETPOINT_TLAST != e.last) begin
                        fails++;
                        $display("FAIL stream_word got=%0d/last%0b exp=%0d/last%0b",
                                 $signed(SETPOINT_TDATA), SETPOINT_TLAST, e.data, e.last);
                    end
                end
                got_q.push_back(int'($signed(SETPOINT_TDATA)));
            end
            prev_v = SETPOINT_TVALID; prev_r = SETPOINT_TREADY;
            prev_d = SETPOINT_TDATA;  prev_l = SETPOINT_TLAST;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, lat;
        int t4_exp[5] = '{1023, 2047, 3071, 4095, 4095};
        int t1_exp[4] = '{50, -50, 3, 0};
        for (int k = 0; k < CH; k++) begin m_gain[k] = 0; m_clip[k] = 0; m_gain_w[k] = 0; m_clip_w[k] = 0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", SETPOINT_TVALID, 0);
        check("rst_tlast", SETPOINT_TLAST, 0);
        check("rst_busy", busy, 0);
        check("rst_tdata", SETPOINT_TDATA, 0);
        check("rst_overrun", overrunCount, 0);
        @(posedge clk); #1; reset_n = 1'b1;

        // Soft-start ramp from reset, then disable
        for (int k = 0; k < CH; k++) write_tbl(k, 32'h7FFF, 1 << 30);
        for (int f = 0; f < 5; f++) begin
            base = got_q.size();
            frame_din[0] = 4096;
            for (int k = 1; k < CH; k++) frame_din[k] = rand_din();
            start_frame();
            if (f == 0) begin
                lat = 0;
                while (!SETPOINT_TVALID && lat < 10) begin @(posedge clk); #1; lat++; end
                check("first_tvalid_latency", lat, 3);
            end
            wait_drain();
            check("ramp_frame_ch0", got_q[base], t4_exp[f]);
        end
        fofbEnabled = 1'b0;
        base = got_q.size();
        start_frame();
        wait_drain();
        check("disabled_frame_ch0", got_q[base], 0);

        // Randomized frames, tables, enable and backpressure
        ready_mode = 1;
        for (int f = 0; f < 20; f++) begin
            fofbEnabled = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1)
                write_tbl($urandom_range(0, CH-1), int'($urandom_range(0, 65535)) - 32768,
                          ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2000)) : int'($urandom & 32'h7FFF_FFFF));
            else
                write_both($urandom_range(0, CH-1), $urandom);
            for (int k = 0; k < CH; k++) frame_din[k] = rand_din();
            start_frame();
            wait_drain();
        end

        // Warm ramp back up to full scale
        ready_mode = 0;
        fofbEnabled = 1'b1;
        for (int k = 0; k < CH; k++) write_tbl(k, 32'h4000, 1 << 30);
        for (int f = 0; f < STEPS; f++) begin
            for (int k = 0; k < CH; k++) frame_din[k] = rand_din();
            start_frame();
            wait_drain();
        end

        // Half gain on a fixed frame
        frame_din = '{100, -100, 7, 0};
        base = got_q.size();
        start_frame();
        wait_drain();
        for (int k = 0; k < CH; k++) check("half_gain_word", got_q[base+k], t1_exp[k]);

        // Ten-cycle stall on word 2
        base = got_q.size();
        start_frame();
        lat = 0;
        while (got_q.size() == base && lat < 50) begin @(negedge clk); lat++; end
        ready_mode = 2;
        repeat (10) @(posedge clk);
        ready_mode = 0;
        wait_drain();
        check("stall_word_count", got_q.size() - base, 4);
        for (int k = 0; k < CH; k++) check("stall_word", got_q[base+k], t1_exp[k]);

        // Clip saturation both signs
        write_tbl(0, 32'h7FFF, 1000);
        write_tbl(1, 32'h7FFF, 1000);
        frame_din = '{1 << 24, -(1 << 24), 5, -5};
        base = got_q.size();
        start_frame();
        wait_drain();
        check("clip_pos", got_q[base], 1000);
        check("clip_neg", got_q[base+1], -1000);

        // Overrun: second toggle two cycles after the first is dropped
        base = got_q.size();
        start_frame();
        @(posedge clk); @(posedge clk); #1;
        dinToggle = ~dinToggle;
        wait_drain();
        check("overrun_one", overrunCount, 1);
        check("overrun_frame_words", got_q.size() - base, 4);
        ready_mode = 2;
        start_frame();
        for (int i = 0; i < 70000; i++) begin @(posedge clk); #1; dinToggle = ~dinToggle; end
        @(negedge clk);
        check("overrun_saturated", overrunCount, 16'hFFFF);
        ready_mode = 0;
        wait_drain();

        // Gain write in the load cycle
        write_tbl(0, 32'h2000, 1 << 30);
        frame_din = '{1000, 1000, 1000, 1000};
        base = got_q.size();
`ifdef FOFB_SETPOINT_SHADOW_EN
        start_frame();
        m_gain_w[0] = 32'h6000;
`else
        m_gain_w[0] = 32'h6000; m_gain[0] = 32'h6000;
        start_frame();
`endif
        @(posedge clk); #1;
        writeAddress = 2'd0; writeData = 32'h6000; gainWriteStrobe = 1'b1;
        @(posedge clk); #1;
        gainWriteStrobe = 1'b0;
        wait_drain();
`ifdef FOFB_SETPOINT_SHADOW_EN
        check("load_write_cur_frame", got_q[base], 250);
`else
        check("load_write_cur_frame", got_q[base], 750);
`endif
        base = got_q.size();
        start_frame();
        wait_drain();
        check("load_write_next_frame", got_q[base], 750);

        // Reset in the middle of SEND
        ready_mode = 2;
        start_frame();
        lat = 0;
        while (!SETPOINT_TVALID && lat < 10) begin @(posedge clk); #1; lat++; end
        check("pre_reset_tvalid", SETPOINT_TVALID, 1);
        reset_n = 1'b0;
        @(posedge clk); @(negedge clk);
        check("mid_reset_tvalid", SETPOINT_TVALID, 0);
        check("mid_reset_overrun", overrunCount, 0);
        check("mid_reset_busy", busy, 0);
        exp_q.delete();
        ramp_m = 0;
        for (int k = 0; k < CH; k++) begin m_gain[k] = 0; m_clip[k] = 0; m_gain_w[k] = 0; m_clip_w[k] = 0; end
        @(posedge clk); #1; reset_n = 1'b1;
        ready_mode = 0;

        // Ramp restarts after reset
        write_tbl(0, 32'h7FFF, 1 << 30);
        frame_din = '{4096, 4096, 4096, 4096};
        base = got_q.size();
        start_frame();
        wait_drain();
        check("post_reset_ch0", got_q[base], 1023);
        check("post_reset_ch1", got_q[base+1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
